// File: rtl/dutb_result_checker.sv
// dutb_result_checker: buffers DUT and reference streams, compares them in order, counts pass/fail, raises sticky stop
module dutb_result_checker #(
  parameter int P_DATA_W       = 32,
  parameter int P_FIFO_DEPTH   = 4,
  parameter int P_MAX_FAIL_NUM = 16,
  parameter int P_CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                dut_valid,
  output logic                dut_ready,
  input  logic [P_DATA_W-1:0] dut_data,
  input  logic                ref_valid,
  output logic                ref_ready,
  input  logic [P_DATA_W-1:0] ref_data,
  input  logic [P_DATA_W-1:0] cmp_mask,
  output logic                res_valid,
  output logic                res_fail,
  output logic [P_CNT_W-1:0]  res_idx,
  output logic [P_DATA_W-1:0] res_diff,
  output logic [P_CNT_W-1:0]  pass_cnt,
  output logic [P_CNT_W-1:0]  fail_cnt,
  output logic                stop
);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  typedef enum logic {RUN, STOP} state_t;
  state_t state, state_nx;
  logic live;
  logic [P_DATA_W-1:0] dmem [P_FIFO_DEPTH];
  logic [P_DATA_W-1:0] rmem [P_FIFO_DEPTH];
  logic [AW:0] dwp, drp, rwp, rrp;
  logic [P_CNT_W-1:0] txn, pass_nx, fail_nx;
  logic [P_DATA_W-1:0] diff;
  logic d_empty, r_empty, d_full, r_full, d_push, r_push, do_cmp, mism;
  assign d_empty = dwp == drp;
  assign r_empty = rwp == rrp;
  assign d_full = (dwp ^ drp) == {1'b1, {AW{1'b0}}};
  assign r_full = (rwp ^ rrp) == {1'b1, {AW{1'b0}}};
  // live holds readys low until the first clock after reset release
  assign dut_ready = live && !d_full && state == RUN;
  assign ref_ready = live && !r_full && state == RUN;
  assign d_push = dut_valid && dut_ready && !clr;
  assign r_push = ref_valid && ref_ready && !clr;
  assign do_cmp = !clr && state == RUN && !d_empty && !r_empty;
  assign diff = (dmem[drp[AW-1:0]] ^ rmem[rrp[AW-1:0]]) & cmp_mask;
  assign mism = |diff;
  assign pass_nx = &pass_cnt ? pass_cnt : pass_cnt + P_CNT_W'(1);
  assign fail_nx = &fail_cnt ? fail_cnt : fail_cnt + P_CNT_W'(1);
  assign stop = state == STOP;
  always_comb begin
    state_nx = state;
    state_nx = clr ? RUN : (do_cmp && mism && fail_nx == P_CNT_W'(P_MAX_FAIL_NUM)) ? STOP : state;
  end
  always_ff @(posedge clk) begin
    if (d_push) dmem[dwp[AW-1:0]] <= dut_data;
    if (r_push) rmem[rwp[AW-1:0]] <= ref_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      live <= 1'b0;
      {dwp, drp, rwp, rrp} <= '0;
      txn <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      res_valid <= 1'b0;
      res_fail <= 1'b0;
      res_idx <= '0;
      res_diff <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      if (clr) begin
        {dwp, drp, rwp, rrp} <= '0;
        txn <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        res_valid <= 1'b0;
        res_fail <= 1'b0;
        res_idx <= '0;
        res_diff <= '0;
      end else begin
        if (d_push) dwp <= dwp + 1'b1;
        if (r_push) rwp <= rwp + 1'b1;
        res_valid <= do_cmp;
        res_fail <= do_cmp && mism;
        if (do_cmp) begin
          drp <= drp + 1'b1;
          rrp <= rrp + 1'b1;
          txn <= txn + P_CNT_W'(1);
          res_idx <= txn;
          res_diff <= diff;
          if (mism) fail_cnt <= fail_nx;
          else pass_cnt <= pass_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_dutb_result_checker.sv
// tb_dutb_result_checker: randomized and directed scenarios checked against a queue-based reference model
module tb_dutb_result_checker;
  localparam int DEPTH = 4;
  localparam int MAX = 16;
  typedef logic [31:0] wq_t[$];
  typedef struct packed {logic fail; logic [15:0] idx; logic [31:0] diff; logic stp;} res_t;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, dv = 1'b0, rv = 1'b0;
  logic [31:0] dd = '0, rd = '0, mask = '1;
  logic dut_ready, ref_ready, res_valid, res_fail, stop;
  logic [15:0] res_idx, pass_cnt, fail_cnt;
  logic [31:0] res_diff;
  int errors = 0, checks = 0;
  logic [31:0] dq[$], rq[$];
  int m_pass = 0, m_fail = 0, m_txn = 0;
  bit m_stop = 0, m_live = 0, acc_d, acc_r;
  res_t e_res, got[$], expq[$];
  bit e_valid = 0;

  dutb_result_checker dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .dut_valid(dv), .dut_ready(dut_ready), .dut_data(dd),
    .ref_valid(rv), .ref_ready(ref_ready), .ref_data(rd),
    .cmp_mask(mask), .res_valid(res_valid), .res_fail(res_fail), .res_idx(res_idx),
    .res_diff(res_diff), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .stop(stop)
  );

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) if (rst_n && res_valid) got.push_back({res_fail, res_idx, res_diff, stop});

  task automatic model_reset();
    dq.delete(); rq.delete();
    m_pass = 0; m_fail = 0; m_txn = 0; m_stop = 0; m_live = 0; e_valid = 0;
  endtask

  // advance one clock: model consumes the inputs held across the edge
  task automatic tick();
    bit dr, rr, cmp;
    logic [31:0] df;
    dr = m_live && dq.size() < DEPTH && !m_stop;
    rr = m_live && rq.size() < DEPTH && !m_stop;
    acc_d = 0; acc_r = 0;
    @(posedge clk);
    if (clr) begin
      dq.delete(); rq.delete();
      m_pass = 0; m_fail = 0; m_txn = 0; m_stop = 0; e_valid = 0;
    end else begin
      cmp = !m_stop && dq.size() > 0 && rq.size() > 0;
      e_valid = cmp;
      if (cmp) begin
        df = (dq.pop_front() ^ rq.pop_front()) & mask;
        if (df != 0) begin
          if (m_fail < 65535) m_fail++;
          if (m_fail == MAX) m_stop = 1;
        end else if (m_pass < 65535) m_pass++;
        e_res = {df != 0, 16'(m_txn), df, m_stop};
        expq.push_back(e_res);
        m_txn++;
      end
      acc_d = dv && dr;
      acc_r = rv && rr;
      if (acc_d) dq.push_back(dd);
      if (acc_r) rq.push_back(rd);
    end
    m_live = 1;
    #1;
  endtask

  task automatic idle(input int n);
    dv = 0; rv = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic feed(input wq_t dw, input wq_t rw, input int maxc, output int nd);
    int i = 0, j = 0;
    for (int c = 0; c < maxc && (i < dw.size() || j < rw.size()); c++) begin
      dv = i < dw.size(); dd = dv ? dw[i] : '0;
      rv = j < rw.size(); rd = rv ? rw[j] : '0;
      tick();
      if (acc_d) i++;
      if (acc_r) j++;
    end
    dv = 0; rv = 0;
    nd = i;
  endtask

  task automatic do_clr();
    clr = 1; tick(); clr = 0;
    got.delete(); expq.delete();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({dut_ready, ref_ready, res_valid, res_fail, stop} !== 5'b0 || {pass_cnt, fail_cnt, res_idx} !== 48'b0 || res_diff !== 32'b0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b%b vld=%b stop=%b pass=%0d fail=%0d, need all 0", dut_ready, ref_ready, res_valid, stop, pass_cnt, fail_cnt);
    end
    @(negedge clk); rst_n = 1; #1;
    checks++;
    if ({dut_ready, ref_ready} !== 2'b00) begin errors++; $display("FAIL ready_before_first_clk: got %b%b need 00", dut_ready, ref_ready); end
    tick();
    checks++;
    if ({dut_ready, ref_ready} !== 2'b11) begin errors++; $display("FAIL ready_after_first_clk: got %b%b need 11", dut_ready, ref_ready); end
  endtask

  task automatic test_equal();
    wq_t w;
    int nd;
    for (int k = 0; k < 8; k++) w.push_back($urandom);
    mask = '1;
    feed(w, w, 40, nd);
    idle(3);
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL equal_count: got %0d results need 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      checks++;
      if (got[k] !== expq[k] || got[k].idx !== 16'(k) || got[k].fail !== 1'b0) begin
        errors++; $display("FAIL equal_res%0d: got %h need %h", k, got[k], expq[k]);
      end
    end
    checks++;
    if (pass_cnt !== 16'd8 || fail_cnt !== 16'd0) begin errors++; $display("FAIL equal_cnt: got pass=%0d fail=%0d need 8/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_bit5();
    wq_t dw, rw;
    int nd;
    for (int k = 0; k < 8; k++) rw.push_back(k == 3 ? 32'h0 : $urandom);
    dw = rw;
    dw[3] = 32'h20;
    do_clr();
    mask = '1;
    feed(dw, rw, 40, nd);
    idle(3);
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL bit5_count: got %0d need 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      checks++;
      if (got[k] !== expq[k] || got[k].fail !== (k == 3) || got[k].diff !== (k == 3 ? 32'h20 : 32'h0)) begin
        errors++; $display("FAIL bit5_res%0d: got %h need %h", k, got[k], expq[k]);
      end
    end
    do_clr();
    mask = ~32'h20;
    feed(dw, rw, 40, nd);
    idle(3);
    checks++;
    if (pass_cnt !== 16'd8 || fail_cnt !== 16'd0 || got.size() != 8) begin
      errors++; $display("FAIL bit5_masked: got pass=%0d fail=%0d n=%0d need 8/0/8", pass_cnt, fail_cnt, got.size());
    end
    mask = '1;
  endtask

  task automatic test_stop();
    wq_t dw, rw;
    int nd;
    do_clr();
    for (int k = 0; k < 20; k++) begin
      rw.push_back($urandom);
      dw.push_back(rw[k] ^ (32'h1 << $urandom_range(0, 31)));
    end
    feed(dw, rw, 60, nd);
    idle(2);
    checks++;
    if (got.size() != 16) begin errors++; $display("FAIL stop_count: got %0d results need 16", got.size()); end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      checks++;
      if (got[k] !== expq[k] || got[k].stp !== (k == 15) || got[k].fail !== 1'b1) begin
        errors++; $display("FAIL stop_res%0d: got %h need %h", k, got[k], expq[k]);
      end
    end
    checks++;
    if (stop !== 1'b1 || fail_cnt !== 16'd16 || {dut_ready, ref_ready} !== 2'b00) begin
      errors++; $display("FAIL stop_state: got stop=%b fail=%0d rdy=%b%b need 1/16/00", stop, fail_cnt, dut_ready, ref_ready);
    end
  endtask

  task automatic test_clr_in_stop();
    wq_t w;
    int nd;
    clr = 1; tick(); clr = 0;
    got.delete(); expq.delete();
    checks++;
    if (stop !== 1'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || {dut_ready, ref_ready} !== 2'b11 || res_valid !== 1'b0) begin
      errors++; $display("FAIL clr_state: got stop=%b pass=%0d fail=%0d rdy=%b%b vld=%b need 0/0/0/11/0", stop, pass_cnt, fail_cnt, dut_ready, ref_ready, res_valid);
    end
    w.push_back($urandom);
    feed(w, w, 10, nd);
    idle(3);
    checks++;
    if (got.size() != 1 || got[0].idx !== 16'd0 || got[0].fail !== 1'b0) begin
      errors++; $display("FAIL clr_first_result: got n=%0d idx=%0d need n=1 idx=0 pass", got.size(), got.size() ? got[0].idx : 16'hffff);
    end
  endtask

  task automatic test_backpressure();
    wq_t dw, rw, none, rest;
    int nd, nr;
    do_clr();
    for (int k = 0; k < 6; k++) dw.push_back($urandom);
    rw = dw;
    feed(dw, none, 8, nd);
    checks++;
    if (nd != DEPTH || dut_ready !== 1'b0 || got.size() != 0) begin
      errors++; $display("FAIL bp_fill: got accepted=%0d dut_ready=%b results=%0d need 4/0/0", nd, dut_ready, got.size());
    end
    for (int k = nd; k < 6; k++) rest.push_back(dw[k]);
    feed(rest, rw, 40, nr);
    idle(3);
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL bp_count: got %0d need 6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      checks++;
      if (got[k] !== expq[k] || got[k].idx !== 16'(k) || got[k].fail !== 1'b0) begin
        errors++; $display("FAIL bp_res%0d: got %h need %h", k, got[k], expq[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wq_t w;
    int nd;
    do_clr();
    for (int k = 0; k < 3; k++) w.push_back($urandom);
    feed(w, w, 20, nd);
    idle(2);
    dv = 1; rv = 1; dd = 32'h5; rd = 32'h5;
    tick();
    dv = 0; rv = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({dut_ready, ref_ready, res_valid, stop} !== 4'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got rdy=%b%b vld=%b stop=%b pass=%0d fail=%0d need all 0", dut_ready, ref_ready, res_valid, stop, pass_cnt, fail_cnt);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    got.delete(); expq.delete();
    #1;
    idle(4);
    checks++;
    if (got.size() != 0 || pass_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_mid_no_result: got results=%0d pass=%0d need 0/0", got.size(), pass_cnt);
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int c = 0; c < 500; c++) begin
      dv = $urandom_range(0, 1); dd = $urandom_range(0, 3);
      rv = $urandom_range(0, 1); rd = $urandom_range(0, 3);
      mask = $urandom_range(0, 3) == 0 ? 32'h1 : '1;
      clr = $urandom_range(0, 59) == 0;
      tick();
      checks++;
      if (dut_ready !== (dq.size() < DEPTH && !m_stop) || ref_ready !== (rq.size() < DEPTH && !m_stop)) begin
        errors++; $display("FAIL rnd_ready c%0d: got %b%b need %b%b", c, dut_ready, ref_ready, dq.size() < DEPTH && !m_stop, rq.size() < DEPTH && !m_stop);
      end
      checks++;
      if (res_valid !== e_valid || (e_valid && {res_fail, res_idx, res_diff} !== {e_res.fail, e_res.idx, e_res.diff})) begin
        errors++; $display("FAIL rnd_result c%0d: got v=%b f=%b i=%0d d=%h need v=%b %h", c, res_valid, res_fail, res_idx, res_diff, e_valid, e_res);
      end
      checks++;
      if (pass_cnt !== 16'(m_pass) || fail_cnt !== 16'(m_fail) || stop !== m_stop) begin
        errors++; $display("FAIL rnd_counters c%0d: got p=%0d f=%0d s=%b need p=%0d f=%0d s=%b", c, pass_cnt, fail_cnt, stop, m_pass, m_fail, m_stop);
      end
    end
    clr = 0; dv = 0; rv = 0; mask = '1;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_bit5();
    test_stop();
    test_clr_in_stop();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
